// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key schedule.
// Produces one 32-bit schedule word per clock into internal storage and serves
// completed 128-bit round keys through a registered, fully pipelined read port.
// Optional feature macro: AES_KS_EQINV_EN adds InvMixColumns on reads with rd_inv.
module aes_key_expander #(
    parameter int unsigned NK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [32*NK_MAX-1:0] key,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [3:0]           ready_cnt,
    input  logic                 rd_en,
    input  logic [3:0]           rd_idx,
    input  logic                 rd_inv,
    output logic                 rd_valid,
    output logic                 rd_hit,
    output logic [127:0]         rd_data
);
    localparam int unsigned DEPTH = 4 * (NK_MAX + 7);
    localparam int unsigned AW    = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as field inverse (a^254, with 0 -> 0) followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(a, a);
        inv = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

`ifdef AES_KS_EQINV_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`else
    // rd_inv is kept on the port for drop-in compatibility but has no effect here
    logic unused_rd_inv;
    assign unused_rd_inv = rd_inv;
`endif

    logic [1:0]    state_q, state_d;
    logic [3:0]    nk_q, nk_d;
    logic [3:0]    nr_q, nr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    kpos_q, kpos_d;   // i mod Nk, avoids a divider for AES-192
    logic [7:0]    rcon_q, rcon_d;
    logic [3:0]    ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_hit_q, rd_hit_d;
    logic [127:0]  rd_data_q, rd_data_d;
    logic [31:0]   w_q [DEPTH];

    logic [3:0]    req_nk, req_nr;
    logic          req_ok;
    logic          load_en, wr_en;
    logic [31:0]   prev, tmp, wr_word;
    logic [AW-1:0] rd_base;

    // Control FSM and schedule word generation
    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        idx_d   = idx_q;
        kpos_d  = kpos_q;
        rcon_d  = rcon_q;
        ready_d = ready_q;
        done_d  = done_q;
        err_d   = 1'b0;
        load_en = 1'b0;
        wr_en   = 1'b0;
        prev    = '0;
        tmp     = '0;
        wr_word = '0;
        case (key_len)
            2'd0:    begin req_nk = 4'd4; req_nr = 4'd10; end
            2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; end
            2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; end
            default: begin req_nk = 4'd0; req_nr = 4'd0;  end
        endcase
        req_ok = (key_len != 2'd3) && (32'(req_nk) <= NK_MAX);

        if (state_q != ST_EXPAND) begin
            if (start && req_ok) begin
                load_en = 1'b1;
                nk_d    = req_nk;
                nr_d    = req_nr;
                idx_d   = AW'(req_nk);
                kpos_d  = 3'd0;
                rcon_d  = 8'h01;
                ready_d = {2'b00, req_nk[3:2]};
                done_d  = 1'b0;
                state_d = ST_EXPAND;
            end else if (start) begin
                err_d = 1'b1;
            end
        end else begin
            wr_en = 1'b1;
            prev  = w_q[idx_q - AW'(1)];
            if (kpos_q == 3'd0) begin
                tmp    = sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0};
                rcon_d = xtime(rcon_q);
            end else if (nk_q == 4'd8 && kpos_q == 3'd4) begin
                tmp = sub_word(prev);
            end else begin
                tmp = prev;
            end
            wr_word = w_q[idx_q - AW'(nk_q)] ^ tmp;
            kpos_d  = ({1'b0, kpos_q} == nk_q - 4'd1) ? 3'd0 : kpos_q + 3'd1;
            if (idx_q[1:0] == 2'b11) ready_d = ready_q + 4'd1;
            if (idx_q == AW'({2'b00, nr_q, 2'b00} + 8'd3)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    // Read port: hit decided against ready count before this edge's update
    always_comb begin
        rd_valid_d = rd_en;
        rd_hit_d   = rd_en && (rd_idx < ready_q);
        rd_data_d  = '0;
        rd_base    = AW'({rd_idx, 2'b00});
        if (rd_hit_d) begin
            rd_data_d = {w_q[rd_base], w_q[rd_base + AW'(1)],
                         w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};
`ifdef AES_KS_EQINV_EN
            if (rd_inv && rd_idx != 4'd0 && rd_idx < nr_q) begin
                rd_data_d = {inv_mix_col(rd_data_d[127:96]), inv_mix_col(rd_data_d[95:64]),
                             inv_mix_col(rd_data_d[63:32]), inv_mix_col(rd_data_d[31:0])};
            end
`endif
        end
    end

    // Control and read-port registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nk_q       <= 4'd0;
            nr_q       <= 4'd0;
            idx_q      <= '0;
            kpos_q     <= 3'd0;
            rcon_q     <= 8'h00;
            ready_q    <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            idx_q      <= idx_d;
            kpos_q     <= kpos_d;
            rcon_q     <= rcon_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Schedule storage: key load on accepted start, one new word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (!rst && load_en) begin
            for (int j = 0; j < int'(NK_MAX); j++) begin
                if (j < int'(req_nk)) w_q[j] <= key[32*NK_MAX-1-32*j -: 32];
            end
        end else if (!rst && wr_en) begin
            w_q[idx_q] <= wr_word;
        end
    end

    assign busy      = (state_q == ST_EXPAND);
    assign done      = done_q;
    assign err       = err_q;
    assign ready_cnt = ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_hit    = rd_hit_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-expansion vectors.
module tb_aes_key_expander;
    localparam int unsigned NK_MAX = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [1:0]           key_len;
    logic [32*NK_MAX-1:0] key;
    logic                 busy, done, err;
    logic [3:0]           ready_cnt;
    logic                 rd_en;
    logic [3:0]           rd_idx;
    logic                 rd_inv;
    logic                 rd_valid, rd_hit;
    logic [127:0]         rd_data;

    always #5 clk = ~clk;

    aes_key_expander #(.NK_MAX(NK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ready_cnt (ready_cnt),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_inv    (rd_inv),
        .rd_valid  (rd_valid),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data)
    );

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                       64'h0};
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct packed {
        logic         hit;
        logic [127:0] data;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns later and retire any read issued on that edge
    task automatic tick();
        logic  issued;
        exp_t  e;
        string t;
        issued = rd_en;
        @(posedge clk);
        #1;
        if (issued) begin
            check("rd_valid", 128'(rd_valid), 128'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL scoreboard_underflow observed=read expected=none");
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_hit"}, 128'(rd_hit), 128'(e.hit));
                check({t, "_data"}, rd_data, e.data);
            end
        end
    endtask

    task automatic rd_issue(input logic [3:0] idx, input logic inv, input logic hit,
                            input logic [127:0] data, input string tag);
        rd_en  = 1'b1;
        rd_idx = idx;
        rd_inv = inv;
        exp_q.push_back({hit, hit ? data : 128'h0});
        tag_q.push_back(tag);
    endtask

    task automatic rd_one(input logic [3:0] idx, input logic inv, input logic hit,
                          input logic [127:0] data, input string tag);
        rd_issue(idx, inv, hit, data, tag);
        tick();
        rd_en  = 1'b0;
        rd_inv = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] len, input logic [255:0] k);
        key_len = len;
        key     = k;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Expect done to rise exactly n edges from now
    task automatic expect_done_after(input int n, input string tag);
        repeat (n - 1) tick();
        check({tag, "_done_early"}, 128'(done), 128'd0);
        check({tag, "_busy_early"}, 128'(busy), 128'd1);
        tick();
        check({tag, "_done"}, 128'(done), 128'd1);
        check({tag, "_busy_end"}, 128'(busy), 128'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_len = 2'd0; key = '0;
        rd_en = 1'b0; rd_idx = 4'd0; rd_inv = 1'b0;
        tick();
        tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ready", 128'(ready_cnt), 128'd0);
        check("rst_rd_data", rd_data, 128'd0);
        rst = 1'b0;
        tick();
        rd_one(4'd0, 1'b0, 1'b0, 128'h0, "idle_rd0");

        // AES-128 with early reads and an ignored start during expansion
        start_run(2'd0, KEY128);
        check("a128_busy_e0", 128'(busy), 128'd1);
        check("a128_ready_e0", 128'(ready_cnt), 128'd1);
        repeat (3) tick();
        rd_issue(4'd1, 1'b0, 1'b0, 128'h0, "a128_early_rd1");
        tick();
        check("a128_ready_e4", 128'(ready_cnt), 128'd2);
        rd_issue(4'd1, 1'b0, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, "a128_rd1");
        tick();
        rd_en   = 1'b0;
        key_len = 2'd2;
        key     = KEY256;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("a128_busy_after_ign", 128'(busy), 128'd1);
        expect_done_after(34, "a128");
        check("a128_ready_end", 128'(ready_cnt), 128'd11);
        rd_issue(4'd10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a128_rd10");
        tick();
        rd_issue(4'd0, 1'b0, 1'b1, KEY128[255:128], "a128_rd0");
        tick();
        rd_issue(4'd11, 1'b0, 1'b0, 128'h0, "a128_rd11");
        tick();
        rd_issue(4'd15, 1'b0, 1'b0, 128'h0, "a128_rd15");
        tick();
        rd_en = 1'b0;
        tick();
        check("rd_valid_pulse", 128'(rd_valid), 128'd0);

        // Illegal key length while DONE
        key_len = 2'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("ill_err", 128'(err), 128'd1);
        check("ill_done", 128'(done), 128'd1);
        check("ill_ready", 128'(ready_cnt), 128'd11);
        tick();
        check("ill_err_pulse", 128'(err), 128'd0);
        rd_one(4'd10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ill_rd10");

        // AES-192 restart from DONE
        start_run(2'd1, KEY192);
        check("a192_done_cleared", 128'(done), 128'd0);
        check("a192_ready_e0", 128'(ready_cnt), 128'd1);
        expect_done_after(46, "a192");
        check("a192_ready_end", 128'(ready_cnt), 128'd13);
        rd_issue(4'd12, 1'b0, 1'b1, 128'he98ba06f448c773c8ecc720401002202, "a192_rd12");
        tick();
        rd_issue(4'd1, 1'b0, 1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, "a192_rd1");
        tick();
        rd_issue(4'd0, 1'b0, 1'b1, KEY192[255:128], "a192_rd0");
        tick();
        rd_issue(4'd13, 1'b0, 1'b0, 128'h0, "a192_rd13");
        tick();
        rd_en = 1'b0;

        // AES-256: round key 1 is the key's low half, readable right away
        start_run(2'd2, KEY256);
        check("a256_ready_e0", 128'(ready_cnt), 128'd2);
        rd_issue(4'd1, 1'b0, 1'b1, KEY256[127:0], "a256_rd1_e1");
        tick();
        rd_issue(4'd2, 1'b0, 1'b0, 128'h0, "a256_rd2_e2");
        tick();
        rd_en = 1'b0;
        expect_done_after(50, "a256");
        check("a256_ready_end", 128'(ready_cnt), 128'd15);
        rd_issue(4'd14, 1'b0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "a256_rd14");
        tick();
        rd_issue(4'd15, 1'b0, 1'b0, 128'h0, "a256_rd15");
        tick();
        rd_en = 1'b0;

        // Reset in the middle of an AES-128 expansion
        start_run(2'd0, KEY128);
        repeat (18) tick();
        rd_issue(4'd0, 1'b0, 1'b1, KEY128[255:128], "mid_rd0");
        tick();
        rd_en = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        check("mrst_busy", 128'(busy), 128'd0);
        check("mrst_done", 128'(done), 128'd0);
        check("mrst_err", 128'(err), 128'd0);
        check("mrst_ready", 128'(ready_cnt), 128'd0);
        check("mrst_rd_valid", 128'(rd_valid), 128'd0);
        check("mrst_rd_hit", 128'(rd_hit), 128'd0);
        check("mrst_rd_data", rd_data, 128'd0);
        rd_one(4'd0, 1'b0, 1'b0, 128'h0, "mrst_rd0");
        key_len = 2'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("idle_ill_err", 128'(err), 128'd1);
        check("idle_ill_busy", 128'(busy), 128'd0);
        start_run(2'd0, KEY128);
        expect_done_after(40, "re128");
        rd_one(4'd10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "re128_rd10");

`ifdef AES_KS_EQINV_EN
        rd_one(4'd0, 1'b1, 1'b1, KEY128[255:128], "eqinv_rd0");
        rd_one(4'd10, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "eqinv_rd10");
`else
        rd_one(4'd1, 1'b1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, "noinv_rd1");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
